regfile_wb_arbiter: RTL and testbench

Shares the single write port (we3/wa3/wd3) of the three-ported register file between two writeback requesters: A (ALU result path) and B (load/memory result path). Both requesters use a valid/ready handshake. Contested cycles are resolved by a round-robin arbiter. The winning request goes into a one-entry registered writeback stage that drives the register file write port. Writes that target register 15 are redirected to a PC write strobe and never reach the register file array.

---
 rtl/regfile_wb_arbiter_if.sv | 42 ++++
 rtl/regfile_wb_arbiter.sv | 121 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter_if
//  Purpose  : Bundles the two writeback requester handshakes (A = ALU result,
//             B = load result) and the register-file / PC write port.
//  Modports : slave  - arbiter side (takes requests, drives write port)
//             master - environment side (drives requests, observes write port)
//  Signals  : a_valid/a_addr/a_data/a_ready, b_valid/b_addr/b_data/b_ready,
//             we3/wa3/wd3, pc_we/pc_wd, busy
//  Revision : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
    parameter int WIDTH        = 16,
    parameter int REGNUM       = 16,
    parameter int ADDRESSWIDTH = 4
);
    logic                    a_valid;
    logic [ADDRESSWIDTH-1:0] a_addr;
    logic [WIDTH-1:0]        a_data;
    logic                    a_ready;
    logic                    b_valid;
    logic [ADDRESSWIDTH-1:0] b_addr;
    logic [WIDTH-1:0]        b_data;
    logic                    b_ready;
    logic                    we3;
    logic [ADDRESSWIDTH-1:0] wa3;
    logic [WIDTH-1:0]        wd3;
    logic                    pc_we;
    logic [WIDTH-1:0]        pc_wd;
    logic [REGNUM-1:0]       busy;

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, we3, wa3, wd3, pc_we, pc_wd, busy
    );

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, we3, wa3, wd3, pc_we, pc_wd, busy
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Purpose  : Round-robin arbitration of two writeback requesters onto the
//             single register-file write port, through a one-entry registered
//             writeback stage. Writes to the last register (PC alias) are
//             redirected to the PC write strobe.
//  Ports    : clk   - system clock, rising edge
//             rst_n - asynchronous active-low reset
//             bus   - regfile_wb_arbiter_if.slave (requests + write port)
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int WIDTH        = 16,
    parameter int REGNUM       = 16,
    parameter int ADDRESSWIDTH = 4
) (
    input  wire                   clk,
    input  wire                   rst_n,
    regfile_wb_arbiter_if.slave   bus
);

    localparam logic [ADDRESSWIDTH-1:0] c_PC_ADDR = ADDRESSWIDTH'(REGNUM - 1);

    // Round-robin pointer: names the side that wins the next contested cycle.
    typedef enum logic [0:0] {
        PTR_A = 1'b0,
        PTR_B = 1'b1
    } ptr_e;

    ptr_e                    r_ptr;
    ptr_e                    w_ptr_next;
    logic                    w_grant_a;
    logic                    w_grant_b;
    logic                    w_win_valid;
    logic [ADDRESSWIDTH-1:0] w_win_addr;
    logic [WIDTH-1:0]        w_win_data;
    logic                    w_win_is_pc;

    // The writeback stage is held directly as the decoded output registers:
    // the register file never stalls, so the stage is rewritten every cycle.
    logic                    r_we3;
    logic [ADDRESSWIDTH-1:0] r_wa3;
    logic [WIDTH-1:0]        r_wd3;
    logic                    r_pc_we;
    logic [WIDTH-1:0]        r_pc_wd;
    logic [REGNUM-1:0]       r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= PTR_A;
        end else begin
            r_ptr <= w_ptr_next;
        end
    end

    always_comb begin
        w_grant_a  = 1'b0;
        w_grant_b  = 1'b0;
        w_ptr_next = r_ptr;
        if (bus.a_valid && bus.b_valid) begin
            // Contested: pointer side wins, pointer moves to the loser.
            if (r_ptr == PTR_A) begin
                w_grant_a  = 1'b1;
                w_ptr_next = PTR_B;
            end else begin
                w_grant_b  = 1'b1;
                w_ptr_next = PTR_A;
            end
        end else if (bus.a_valid) begin
            w_grant_a = 1'b1;
        end else if (bus.b_valid) begin
            w_grant_b = 1'b1;
        end
    end

    // Readies are suppressed while reset is held so no transfer is signalled.
    assign bus.a_ready = w_grant_a & rst_n;
    assign bus.b_ready = w_grant_b & rst_n;

    assign w_win_valid = w_grant_a | w_grant_b;
    assign w_win_addr  = w_grant_b ? bus.b_addr : bus.a_addr;
    assign w_win_data  = w_grant_b ? bus.b_data : bus.a_data;
    assign w_win_is_pc = (w_win_addr == c_PC_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we3   <= 1'b0;
            r_wa3   <= '0;
            r_wd3   <= '0;
            r_pc_we <= 1'b0;
            r_pc_wd <= '0;
            r_busy  <= '0;
        end else if (w_win_valid && w_win_is_pc) begin
            // PC alias never reaches the array; wa3/wd3 keep their last values.
            r_we3   <= 1'b0;
            r_pc_we <= 1'b1;
            r_pc_wd <= w_win_data;
            r_busy  <= '0;
        end else if (w_win_valid) begin
            r_we3   <= 1'b1;
            r_wa3   <= w_win_addr;
            r_wd3   <= w_win_data;
            r_pc_we <= 1'b0;
            r_busy  <= REGNUM'(1) << w_win_addr;
        end else begin
            r_we3   <= 1'b0;
            r_pc_we <= 1'b0;
            r_busy  <= '0;
        end
    end

    assign bus.we3   = r_we3;
    assign bus.wa3   = r_wa3;
    assign bus.wd3   = r_wd3;
    assign bus.pc_we = r_pc_we;
    assign bus.pc_wd = r_pc_wd;
    assign bus.busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wb_arbiter
//  Purpose  : Self-checking bench for regfile_wb_arbiter. A vector table gives
//             per-cycle requests and the expected readies; the expected write
//             port contents for the following cycle are queued and compared
//             after the edge. Reset behaviour is exercised by hand sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    logic clk;
    logic rst_n;

    regfile_wb_arbiter_if #(.WIDTH(16), .REGNUM(16), .ADDRESSWIDTH(4)) bus ();

    regfile_wb_arbiter #(.WIDTH(16), .REGNUM(16), .ADDRESSWIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [3:0]  aa;
        logic [15:0] ad;
        logic        bv;
        logic [3:0]  ba;
        logic [15:0] bd;
        logic        er_a;
        logic        er_b;
    } vec_t;

    typedef struct {
        logic        we3;
        logic [3:0]  wa3;
        logic [15:0] wd3;
        logic        pc_we;
        logic [15:0] pc_wd;
        logic [15:0] busy;
    } out_t;

    out_t  sb[$];
    vec_t  vecs[15];
    logic [15:0] rf[16];

    int n_pass  = 0;
    int n_total = 0;

    // Environment register file, committed from the write port.
    always @(posedge clk) begin
        if (bus.we3 === 1'b1) rf[bus.wa3] <= bus.wd3;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_out(input string tag);
        out_t e;
        if (sb.size() == 0) begin
            n_total++;
            $display("FAIL %s: scoreboard empty got 1 expected 0", tag);
            return;
        end
        e = sb.pop_front();
        chk($sformatf("%s/we3", tag),   32'(bus.we3),   32'(e.we3));
        chk($sformatf("%s/pc_we", tag), 32'(bus.pc_we), 32'(e.pc_we));
        chk($sformatf("%s/busy", tag),  32'(bus.busy),  32'(e.busy));
        if (e.we3) begin
            chk($sformatf("%s/wa3", tag), 32'(bus.wa3), 32'(e.wa3));
            chk($sformatf("%s/wd3", tag), 32'(bus.wd3), 32'(e.wd3));
        end
        if (e.pc_we) chk($sformatf("%s/pc_wd", tag), 32'(bus.pc_wd), 32'(e.pc_wd));
    endtask

    task automatic apply(input vec_t v, input string tag);
        out_t        e;
        logic [3:0]  addr;
        logic [15:0] data;
        bus.a_valid = v.av; bus.a_addr = v.aa; bus.a_data = v.ad;
        bus.b_valid = v.bv; bus.b_addr = v.ba; bus.b_data = v.bd;
        #2;
        chk($sformatf("%s/a_ready", tag), 32'(bus.a_ready), 32'(v.er_a));
        chk($sformatf("%s/b_ready", tag), 32'(bus.b_ready), 32'(v.er_b));
        e = '{we3: 1'b0, wa3: 4'h0, wd3: 16'h0, pc_we: 1'b0, pc_wd: 16'h0, busy: 16'h0};
        if (v.er_a || v.er_b) begin
            addr = v.er_a ? v.aa : v.ba;
            data = v.er_a ? v.ad : v.bd;
            if (addr == 4'hF) begin
                e.pc_we = 1'b1;
                e.pc_wd = data;
            end else begin
                e.we3  = 1'b1;
                e.wa3  = addr;
                e.wd3  = data;
                e.busy = 16'h0001 << addr;
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 16'h0;

        //          av  aa     ad        bv  ba     bd        er_a er_b
        vecs[0]  = '{0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 0, 0};   // idle
        vecs[1]  = '{1, 4'h3, 16'h1234, 0, 4'h0, 16'h0000, 1, 0};   // single write
        vecs[2]  = '{0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 0, 0};   // we3 drops
        vecs[3]  = '{1, 4'h1, 16'h00AA, 1, 4'h2, 16'h00BB, 1, 0};   // contest, ptr A
        vecs[4]  = '{1, 4'h1, 16'h00AA, 1, 4'h2, 16'h00BB, 0, 1};   // contest, ptr B
        vecs[5]  = '{1, 4'h6, 16'h0666, 1, 4'h5, 16'h0002, 1, 0};   // ptr back at A
        vecs[6]  = '{1, 4'h5, 16'h0001, 1, 4'h5, 16'h0002, 0, 1};   // same target, ptr B
        vecs[7]  = '{1, 4'h5, 16'h0001, 0, 4'h0, 16'h0000, 1, 0};   // A within 2 cycles
        vecs[8]  = '{0, 4'h0, 16'h0000, 1, 4'hF, 16'h0040, 0, 1};   // PC redirect
        vecs[9]  = '{0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 0, 0};
        vecs[10] = '{1, 4'hF, 16'h0080, 1, 4'h3, 16'h3333, 1, 0};   // contested PC write
        vecs[11] = '{0, 4'h0, 16'h0000, 1, 4'h3, 16'h3333, 0, 1};
        vecs[12] = '{1, 4'h0, 16'hFFFF, 0, 4'h0, 16'h0000, 1, 0};   // lowest register
        vecs[13] = '{0, 4'h0, 16'h0000, 1, 4'hE, 16'hBEEF, 0, 1};   // highest real register
        vecs[14] = '{0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 0, 0};

        // Reset held for 2 cycles with requests pending: no ready, no write.
        rst_n = 1'b0;
        bus.a_valid = 1'b1; bus.a_addr = 4'h1; bus.a_data = 16'h00AA;
        bus.b_valid = 1'b1; bus.b_addr = 4'h2; bus.b_data = 16'h00BB;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rst%0d/a_ready", c), 32'(bus.a_ready), 32'h0);
            chk($sformatf("rst%0d/b_ready", c), 32'(bus.b_ready), 32'h0);
            chk($sformatf("rst%0d/we3", c),     32'(bus.we3),     32'h0);
            chk($sformatf("rst%0d/pc_we", c),   32'(bus.pc_we),   32'h0);
            chk($sformatf("rst%0d/busy", c),    32'(bus.busy),    32'h0);
        end
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) apply(vecs[i], $sformatf("v%0d", i));

        chk("rf5_final", 32'(rf[5]), 32'h0001);
        chk("rf3_final", 32'(rf[3]), 32'h3333);
        chk("rf15_untouched", 32'(rf[15]), 32'h0000);

        // Reset while an entry sits in the writeback stage.
        apply('{1, 4'h7, 16'h7777, 0, 4'h0, 16'h0000, 1, 0}, "mid");
        #2;
        rst_n = 1'b0;
        bus.a_valid = 1'b0;
        #1;
        chk("midrst/we3",  32'(bus.we3),  32'h0);
        chk("midrst/busy", 32'(bus.busy), 32'h0);
        chk("midrst/wa3",  32'(bus.wa3),  32'h0);
        @(posedge clk);
        #1;
        chk("midrst/rf7", 32'(rf[7]), 32'h0000);
        rst_n = 1'b1;
        apply('{0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 0, 0}, "post");
        // Pointer returned to A by reset.
        apply('{1, 4'h8, 16'h0808, 1, 4'h9, 16'h0909, 1, 0}, "postptr");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
